team_06_pb_event_unit: RTL and testbench
========================================

// Module: team_06_pb_event_unit
// PURPOSE
//  Parametrised pushbutton front end for the team_06 FPGA/caravel top.
//  Synchronises and debounces NUM_PB raw buttons, then emits one-cycle press/release pulses.
//  Encodes the lowest-index new press into a one-entry key-event buffer, with a valid/ack handshake
//  and a sticky overflow flag. Sits between the board pb inputs and the team_06 core, replacing raw pb wiring.
// PARAMETERS
//  NUM_PB     21  number of button channels (>=1)
//  DB_CYCLES  4   consecutive disagreeing samples needed to accept a new level (>=2)
//  KEY_W      $clog2(NUM_PB) (5 for NUM_PB=21)  key_code width; derived, do not override
// PORTS
//  hwclk     in   1       system clock; all logic on posedge
//  reset     in   1       synchronous, active-high reset
//  pb        in   NUM_PB  raw asynchronous button levels, 1 = pressed
//  pb_clean  out  NUM_PB  debounced levels
//  pb_rise   out  NUM_PB  1-cycle pulse on accepted press, per channel
//  pb_fall   out  NUM_PB  1-cycle pulse on accepted release, per channel
//  key_valid out  1       key-event buffer holds an unconsumed event
//  key_code  out  KEY_W   index of buffered press; valid only while key_valid=1
//  key_ack   in   1       consumer pops the event; honoured only while key_valid=1
//  key_ovf   out  1       sticky: a press event was dropped
//  ovf_clr   in   1       clears key_ovf
// BEHAVIOUR
//  Reset, synchronous, dominates all inputs: sync flops, counters, pb_clean, pb_rise, pb_fall = 0;
//  key_valid=0, key_code=0, key_ovf=0. Reset mid-debounce discards partial counts.
//  Sync: pb -> s1 -> s2, two flops per channel. No logic reads s1.
//  Debounce, per channel, counter cnt of width $clog2(DB_CYCLES), evaluated each edge:
//   - s2==pb_clean          : cnt<=0
//   - s2!=pb_clean, cnt<DB_CYCLES-1 : cnt<=cnt+1
//   - s2!=pb_clean, cnt==DB_CYCLES-1: pb_clean<=s2, cnt<=0
//   - A single matching sample restarts the count (glitch rejection).
//  Latency: pb held stable from before edge 0 -> pb_clean changes at edge DB_CYCLES+1.
//   That is DB_CYCLES+2 edges; 6 edges for the default.
//  pb_rise/pb_fall are registered and go high on the same edge pb_clean changes, for exactly 1 cycle.
//  Channels are independent; simultaneous accepts on several channels pulse together.
//  Key buffer, evaluated each edge; new = |pb_rise; idx = lowest set bit of pb_rise:
//   - new & (!key_valid | key_ack) : key_code<=idx, key_valid<=1 (ack+new same cycle = back-to-back, no bubble)
//   - new &  key_valid & !key_ack  : event dropped, key_code unchanged, key_ovf<=1
//   - !new & key_ack & key_valid   : key_valid<=0
//   - key_ack while key_valid=0 is ignored
//   - multiple bits in pb_rise in one cycle: only lowest index is buffered, rest dropped, key_ovf<=1
//  key_ovf: cleared by ovf_clr. If ovf_clr and a new drop occur in the same cycle, set wins.
//  pb_fall never touches the key buffer.
// TESTING
//  1 Reset: hold reset 3 cycles with pb=all 1 -> every output 0; after release pb_clean[all] rises at edge 6.
//  2 Debounce: pb[3] toggles 1,0,1,0 each cycle, then stays 1 -> no pulse during bounce;
//    pb_rise[3] single pulse 6 edges after last toggle; pb_clean[3]=1.
//  3 Latency/fall: pb[20]=1 for 10 cycles, then 0 -> pb_rise[20] at edge 6; pb_fall[20] 6 edges after drop.
//    key_code=20 with key_valid=1 after the rise.
//  4 Handshake: press pb[7]; pulse key_ack in the same cycle pb_rise[5] occurs -> key_code 7 then 5;
//    key_valid stays 1 throughout; key_ovf=0.
//  5 Overflow: press pb[2], no ack, press pb[9] -> key_code stays 2, key_ovf=1.
//    ovf_clr -> key_ovf=0. Then ack -> key_valid=0.
//  6 Simultaneous: pb[4] and pb[1] asserted together -> pb_rise=0x12 in one cycle, key_code=1, key_ovf=1.
//    Assert reset mid-count -> pb_clean stays 0.

Source files
------------

// File: rtl/team_06_pb_event_unit_if.sv
// Key-event handshake bundle between the pushbutton front end and its consumer.
//   key_valid : buffer holds an unconsumed press event        (producer -> consumer)
//   key_code  : index of the buffered press, valid with key_valid (producer -> consumer)
//   key_ovf   : sticky flag, a press event was dropped          (producer -> consumer)
//   key_ack   : consumer pops the buffered event                (consumer -> producer)
//   ovf_clr   : consumer clears key_ovf                         (consumer -> producer)
interface team_06_pb_event_unit_if #(
   parameter int KEY_W = 5
);
   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic             key_ovf;
   logic             key_ack;
   logic             ovf_clr;

   modport master (
      output key_valid,
      output key_code,
      output key_ovf,
      input  key_ack,
      input  ovf_clr
   );

   modport slave (
      input  key_valid,
      input  key_code,
      input  key_ovf,
      output key_ack,
      output ovf_clr
   );
endinterface

// File: rtl/team_06_pb_event_unit.sv
// Pushbutton front end: two-flop synchroniser and per-channel debounce for
// NUM_PB raw buttons, one-cycle press/release pulses, and a one-entry key-event
// buffer holding the lowest-index new press with a sticky overflow flag.
// Ports:
//   hwclk    : system clock, all logic on posedge
//   reset    : synchronous active-high reset, dominates every input
//   pb       : raw asynchronous button levels, 1 = pressed
//   pb_clean : debounced levels
//   pb_rise  : one-cycle pulse per channel on an accepted press
//   pb_fall  : one-cycle pulse per channel on an accepted release
//   key_bus  : key-event handshake (key_valid/key_code/key_ovf out, key_ack/ovf_clr in)
module team_06_pb_event_unit #(
   parameter  int NUM_PB    = 21,
   parameter  int DB_CYCLES = 4,
   localparam int KEY_W     = (NUM_PB > 1) ? $clog2(NUM_PB) : 1,
   localparam int CNT_W     = $clog2(DB_CYCLES)
) (
   input  logic                 hwclk,
   input  logic                 reset,
   input  logic [NUM_PB-1:0]    pb,
   output logic [NUM_PB-1:0]    pb_clean,
   output logic [NUM_PB-1:0]    pb_rise,
   output logic [NUM_PB-1:0]    pb_fall,
   team_06_pb_event_unit_if.master key_bus
);

   logic [NUM_PB-1:0] s1;
   logic [NUM_PB-1:0] s2;
   logic [CNT_W-1:0]  cnt [NUM_PB];
   logic [NUM_PB-1:0] accept;

   logic              new_evt;
   logic              multi;
   logic              drop;
   logic [KEY_W-1:0]  idx;

   // A channel accepts its new level on the DB_CYCLES-th consecutive
   // disagreeing sample; any matching sample in between restarts the count.
   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_PB; i++) begin
         accept[i] = (s2[i] != pb_clean[i]) && (cnt[i] == CNT_W'(DB_CYCLES - 1));
      end
   end

   always_ff @(posedge hwclk) begin
      if (reset) begin
         s1       <= '0;
         s2       <= '0;
         pb_clean <= '0;
         pb_rise  <= '0;
         pb_fall  <= '0;
         for (int i = 0; i < NUM_PB; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1       <= pb;
         s2       <= s1;
         pb_clean <= (pb_clean & ~accept) | (s2 & accept);
         pb_rise  <= accept & s2;
         pb_fall  <= accept & ~s2;
         for (int i = 0; i < NUM_PB; i++) begin
            if ((s2[i] == pb_clean[i]) || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Lowest set bit of pb_rise wins; scanning downwards leaves the lowest index last.
   always_comb begin
      idx = '0;
      for (int i = NUM_PB - 1; i >= 0; i--) begin
         if (pb_rise[i]) begin
            idx = KEY_W'(i);
         end
      end
   end

   assign new_evt = |pb_rise;
   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign multi   = |(pb_rise & (pb_rise - NUM_PB'(1)));
   assign drop    = new_evt && ((key_bus.key_valid && !key_bus.key_ack) || multi);

   always_ff @(posedge hwclk) begin
      if (reset) begin
         key_bus.key_valid <= 1'b0;
         key_bus.key_code  <= '0;
         key_bus.key_ovf   <= 1'b0;
      end else begin
         // An ack in the same cycle as a new press frees the slot for it directly.
         if (new_evt && (!key_bus.key_valid || key_bus.key_ack)) begin
            key_bus.key_valid <= 1'b1;
            key_bus.key_code  <= idx;
         end else if (!new_evt && key_bus.key_ack && key_bus.key_valid) begin
            key_bus.key_valid <= 1'b0;
         end

         // A drop in the same cycle as ovf_clr keeps the flag set.
         if (drop) begin
            key_bus.key_ovf <= 1'b1;
         end else if (key_bus.ovf_clr) begin
            key_bus.key_ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_team_06_pb_event_unit.sv
module tb_team_06_pb_event_unit;
   localparam int N  = 21;
   localparam int DB = 4;

   logic         hwclk = 1'b0;
   logic         reset;
   logic [N-1:0] pb;
   logic [N-1:0] pb_clean;
   logic [N-1:0] pb_rise;
   logic [N-1:0] pb_fall;

   int checks   = 0;
   int failures = 0;

   team_06_pb_event_unit_if #(.KEY_W(5)) kif ();

   team_06_pb_event_unit #(.NUM_PB(N), .DB_CYCLES(DB)) dut (
      .hwclk    (hwclk),
      .reset    (reset),
      .pb       (pb),
      .pb_clean (pb_clean),
      .pb_rise  (pb_rise),
      .pb_fall  (pb_fall),
      .key_bus  (kif.master)
   );

   always #5 hwclk = ~hwclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sync is a two-stage delay; a channel adopts the opposite
   // level once its last DB synchronised samples (since reset) all disagree
   // with the current clean level. Key buffer follows the press/ack/drop rules.
   logic [N-1:0]  m_s1, m_s2, m_clean, m_rise, m_fall;
   logic [DB-1:0] m_win [N];
   int            m_nval [N];
   logic          m_valid, m_ovf;
   int            m_code;
   bit            m_live = 1'b0;

   always @(posedge hwclk) begin
      logic [N-1:0] n_clean, n_rise, n_fall;
      int           lowest, nset, n_code;
      logic         n_valid, n_ovf;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
         m_valid = 1'b0; m_ovf = 1'b0; m_code = 0;
         for (int i = 0; i < N; i++) begin
            m_win[i]  = '0;
            m_nval[i] = 0;
         end
         m_live = 1'b1;
      end else begin
         nset   = $countones(m_rise);
         lowest = 0;
         for (int i = N - 1; i >= 0; i--) if (m_rise[i]) lowest = i;
         n_valid = m_valid; n_code = m_code; n_ovf = m_ovf;
         if (kif.ovf_clr) n_ovf = 1'b0;
         if (nset > 0) begin
            if (!m_valid || kif.key_ack) begin
               n_valid = 1'b1;
               n_code  = lowest;
               if (nset > 1) n_ovf = 1'b1;
            end else begin
               n_ovf = 1'b1;
            end
         end else if (kif.key_ack && m_valid) begin
            n_valid = 1'b0;
         end

         n_clean = m_clean; n_rise = '0; n_fall = '0;
         for (int i = 0; i < N; i++) begin
            m_win[i] = {m_win[i][DB-2:0], m_s2[i]};
            if (m_nval[i] < DB) m_nval[i]++;
            if (m_nval[i] >= DB && m_win[i] == {DB{~m_clean[i]}}) begin
               n_clean[i] = m_s2[i];
               n_rise[i]  = m_s2[i];
               n_fall[i]  = ~m_s2[i];
            end
         end
         m_s2 = m_s1; m_s1 = pb;
         m_clean = n_clean; m_rise = n_rise; m_fall = n_fall;
         m_valid = n_valid; m_code = n_code; m_ovf = n_ovf;
      end
   end

   always @(negedge hwclk) begin
      if (m_live) begin
         chk("pb_clean", 32'(pb_clean), 32'(m_clean));
         chk("pb_rise", 32'(pb_rise), 32'(m_rise));
         chk("pb_fall", 32'(pb_fall), 32'(m_fall));
         chk("key_valid", 32'(kif.key_valid), 32'(m_valid));
         if (m_valid) chk("key_code", 32'(kif.key_code), m_code);
         chk("key_ovf", 32'(kif.key_ovf), 32'(m_ovf));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge hwclk);
   endtask

   task automatic do_reset();
      pb = '0; kif.key_ack = 1'b0; kif.ovf_clr = 1'b0; reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pb = '1; kif.key_ack = 1'b0; kif.ovf_clr = 1'b0;

      // reset with all buttons pressed, then full-latency accept on every channel
      tick(3);
      chk("t1_rst_clean", 32'(pb_clean), 32'h0);
      chk("t1_rst_rise", 32'(pb_rise), 32'h0);
      chk("t1_rst_fall", 32'(pb_fall), 32'h0);
      chk("t1_rst_valid", 32'(kif.key_valid), 32'h0);
      chk("t1_rst_code", 32'(kif.key_code), 32'h0);
      chk("t1_rst_ovf", 32'(kif.key_ovf), 32'h0);
      reset = 1'b0;
      tick(5);
      chk("t1_clean_e5", 32'(pb_clean), 32'h0);
      tick(1);
      chk("t1_clean_e6", 32'(pb_clean), 32'h1F_FFFF);
      chk("t1_rise_e6", 32'(pb_rise), 32'h1F_FFFF);
      chk("t1_model_clean", 32'(m_clean), 32'h1F_FFFF);
      tick(1);
      chk("t1_code", 32'(kif.key_code), 32'h0);
      chk("t1_ovf", 32'(kif.key_ovf), 32'h1);

      // bounce on pb[3]
      do_reset();
      for (int k = 0; k < 4; k++) begin
         pb[3] = (k % 2 == 0);
         tick(1);
         chk("t2_bounce_rise", 32'(pb_rise), 32'h0);
      end
      pb[3] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         chk("t2_wait_rise", 32'(pb_rise), 32'h0);
      end
      tick(1);
      chk("t2_rise", 32'(pb_rise), 32'h8);
      chk("t2_clean", 32'(pb_clean), 32'h8);
      tick(1);
      chk("t2_rise_once", 32'(pb_rise), 32'h0);

      // latency and release on pb[20]
      do_reset();
      pb[20] = 1'b1;
      tick(5);
      chk("t3_rise_e5", 32'(pb_rise), 32'h0);
      tick(1);
      chk("t3_rise_e6", 32'(pb_rise), 32'h10_0000);
      chk("t3_model_rise", 32'(m_rise), 32'h10_0000);
      tick(1);
      chk("t3_valid", 32'(kif.key_valid), 32'h1);
      chk("t3_code", 32'(kif.key_code), 32'd20);
      tick(3);
      pb[20] = 1'b0;
      tick(5);
      chk("t3_fall_e5", 32'(pb_fall), 32'h0);
      tick(1);
      chk("t3_fall_e6", 32'(pb_fall), 32'h10_0000);
      chk("t3_clean_low", 32'(pb_clean), 32'h0);

      // ack in the same cycle as a new press
      do_reset();
      pb[7] = 1'b1;
      tick(3);
      pb[5] = 1'b1;
      tick(3);
      chk("t4_rise7", 32'(pb_rise), 32'h80);
      tick(1);
      chk("t4_valid7", 32'(kif.key_valid), 32'h1);
      chk("t4_code7", 32'(kif.key_code), 32'd7);
      tick(1);
      chk("t4_valid8", 32'(kif.key_valid), 32'h1);
      tick(1);
      chk("t4_rise5", 32'(pb_rise), 32'h20);
      chk("t4_code_hold", 32'(kif.key_code), 32'd7);
      kif.key_ack = 1'b1;
      tick(1);
      kif.key_ack = 1'b0;
      chk("t4_valid_b2b", 32'(kif.key_valid), 32'h1);
      chk("t4_code5", 32'(kif.key_code), 32'd5);
      chk("t4_ovf", 32'(kif.key_ovf), 32'h0);

      // overflow, clear, ack
      do_reset();
      pb[2] = 1'b1;
      tick(3);
      pb[9] = 1'b1;
      tick(4);
      chk("t5_code2", 32'(kif.key_code), 32'd2);
      tick(3);
      chk("t5_code_kept", 32'(kif.key_code), 32'd2);
      chk("t5_ovf_set", 32'(kif.key_ovf), 32'h1);
      chk("t5_model_ovf", 32'(m_ovf), 32'h1);
      kif.ovf_clr = 1'b1;
      tick(1);
      kif.ovf_clr = 1'b0;
      chk("t5_ovf_clr", 32'(kif.key_ovf), 32'h0);
      chk("t5_valid_kept", 32'(kif.key_valid), 32'h1);
      kif.key_ack = 1'b1;
      tick(1);
      kif.key_ack = 1'b0;
      chk("t5_valid_pop", 32'(kif.key_valid), 32'h0);

      // simultaneous presses, then reset in the middle of a count
      do_reset();
      pb[4] = 1'b1; pb[1] = 1'b1;
      tick(6);
      chk("t6_rise", 32'(pb_rise), 32'h12);
      tick(1);
      chk("t6_code", 32'(kif.key_code), 32'd1);
      chk("t6_ovf", 32'(kif.key_ovf), 32'h1);
      do_reset();
      pb[0] = 1'b1;
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(5);
      chk("t6_clean_after_rst", 32'(pb_clean), 32'h0);
      tick(1);
      chk("t6_clean_restart", 32'(pb_clean), 32'h1);

      // randomized traffic
      do_reset();
      repeat (4000) begin
         @(negedge hwclk);
         reset = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 39) == 0) pb[i] = ~pb[i];
         end
         kif.key_ack = ($urandom_range(0, 3) == 0);
         kif.ovf_clr = ($urandom_range(0, 19) == 0);
      end
      reset = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
